req_chan_rcvr: RTL

Target-side receiver for the request channel: accepts `a_valid`/`a_id`/`a_addr`/`a_atop` beats from whichever initiator currently owns the bus, and buffers them in a small FIFO. It presents the beats in order to the local slave core over a valid/ready interface. It sits between the shared request bus and each memory/peripheral target, and is the counterpart of the initiator-side request channel manager.

---
 rtl/tiny_axi_pkg.sv | 17 +
 rtl/req_chan_rcvr_if.sv | 14 +
 rtl/req_chan_rcvr_fifo.sv | 70 +++++++
 rtl/req_chan_rcvr.sv | 66 ++++++
 4 files changed

// File: rtl/tiny_axi_pkg.sv
// Shared request-channel definitions: field widths, the supported atomic opcode
// and the buffered beat format used by the target-side receiver.
package tiny_axi_pkg;

  localparam int A_ID_W   = 4;
  localparam int A_ADDR_W = 32;
  localparam int A_ATOP_W = 6;

  localparam logic [A_ATOP_W-1:0] ATOP_NONE = 6'b000000;

  typedef struct packed {
    logic [A_ID_W-1:0]   id;
    logic [A_ADDR_W-1:0] addr;
    logic                err;
  } req_beat_t;

endpackage

// File: rtl/req_chan_rcvr_if.sv
// Request-channel bundle between the bus owner (master) and a target receiver (slave).
interface req_chan_rcvr_if;
  import tiny_axi_pkg::*;

  logic                a_valid;
  logic                a_ready;
  logic [A_ID_W-1:0]   a_id;
  logic [A_ADDR_W-1:0] a_addr;
  logic [A_ATOP_W-1:0] a_atop;

  modport master (output a_valid, a_id, a_addr, a_atop, input a_ready);
  modport slave  (input a_valid, a_id, a_addr, a_atop, output a_ready);

endinterface

// File: rtl/req_chan_rcvr_fifo.sv
// Register-array FIFO of request beats with wrapping pointers, an occupancy count
// and a synchronous flush; exposes the next count so the owner can register ready.
module req_fifo
  import tiny_axi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  req_beat_t     wdata_i,
  output req_beat_t     rdata_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o
);

  localparam int PW = $clog2(DEPTH);

  req_beat_t     mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Guard against overflow/underflow even if the owner misbehaves.
  assign push_ok = push_i & (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i  & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign rdata_o      = mem_q[rptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/req_chan_rcvr.sv
// Target-side request channel receiver: buffers accepted beats in order, tags
// unsupported atomics as errors and presents the head beat to the local slave core.
module req_chan_rcvr
  import tiny_axi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  req_chan_rcvr_if.slave      a_ch,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [A_ID_W-1:0]   out_id,
  output logic [A_ADDR_W-1:0] out_addr,
  output logic                out_err,
  output logic [CW-1:0]       count
);

  logic          a_ready_q, a_ready_d;
  logic          push, pop;
  logic [CW-1:0] count_next;
  req_beat_t     wbeat, head;

  assign push = a_ch.a_valid & a_ready_q;
  assign pop  = out_valid & out_ready;

  // Atomics are accepted and marked rather than dropped; the core answers with an error.
  assign wbeat.id   = a_ch.a_id;
  assign wbeat.addr = a_ch.a_addr;
  assign wbeat.err  = (a_ch.a_atop != ATOP_NONE);

  req_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (flush),
    .wdata_i      (wbeat),
    .rdata_o      (head),
    .count_o      (count),
    .count_next_o (count_next)
  );

  // Ready comes only from registered state so out_ready never reaches a_ready combinationally.
  assign a_ready_d = (count_next < CW'(DEPTH)) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ready_q <= 1'b0;
    end else begin
      a_ready_q <= a_ready_d;
    end
  end

  assign a_ch.a_ready = a_ready_q;
  assign out_valid    = (count != '0);
  assign out_id       = head.id;
  assign out_addr     = head.addr;
  assign out_err      = head.err;

endmodule
